// File: rtl/button_pkg.sv
// ----------------------------------------------------------------------------
// button_pkg
// Shared definitions for the five-button event front end.
//   btn_idx_e   : button index / event code (up highest priority, center lowest)
//   NUM_BTN     : number of push-button channels
//   EVT_CODE_W  : width of the event code
//   lowest_onehot / onehot_to_idx : fixed-priority selection helpers
// ----------------------------------------------------------------------------
package button_pkg;

    localparam int NUM_BTN    = 5;
    localparam int EVT_CODE_W = 3;

    typedef enum logic [EVT_CODE_W-1:0] {
        BTN_UP     = 3'd0,
        BTN_LEFT   = 3'd1,
        BTN_RIGHT  = 3'd2,
        BTN_DOWN   = 3'd3,
        BTN_CENTER = 3'd4
    } btn_idx_e;

    // Isolate the lowest set bit: lowest index wins.
    function automatic logic [NUM_BTN-1:0] lowest_onehot(input logic [NUM_BTN-1:0] v);
        return v & (~v + 1'b1);
    endfunction

    function automatic logic [EVT_CODE_W-1:0] onehot_to_idx(input logic [NUM_BTN-1:0] oh);
        logic [EVT_CODE_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (oh[i]) idx = EVT_CODE_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/button_debounce_ch.sv
// ----------------------------------------------------------------------------
// button_debounce_ch
// One push-button channel: 2-flop synchroniser, debounce counter and
// auto-repeat timer.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_btn          : raw asynchronous button level
//   i_repeat_en    : allow auto-repeat pulses
//   o_state        : debounced level
//   o_press        : one-cycle pulse in the first cycle o_state is high
//   o_repeat       : one-cycle auto-repeat pulse
// ----------------------------------------------------------------------------
module button_debounce_ch #(
    parameter int DEBOUNCE_CYCLES = 1500000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000,
    parameter int CNT_W           = 26
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    input  logic i_repeat_en,
    output logic o_state,
    output logic o_press,
    output logic o_repeat
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_state;
    logic             r_state_d;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_rcnt;
    logic             r_first;   // next repeat uses the initial delay
    logic             r_rep;

    logic             w_active;
    logic [CNT_W-1:0] w_rlast;

    assign w_active = r_state & i_repeat_en;
    assign w_rlast  = r_first ? DLY_LAST : PER_LAST;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_state   <= 1'b0;
            r_state_d <= 1'b0;
            r_cnt     <= '0;
            r_rcnt    <= '0;
            r_first   <= 1'b1;
            r_rep     <= 1'b0;
        end else begin
            r_sync1   <= i_btn;
            r_sync2   <= r_sync1;
            r_state_d <= r_state;

            // Any agreeing sample restarts the stability window.
            if (r_sync2 != r_state) begin
                if (r_cnt == DEB_LAST) begin
                    r_state <= ~r_state;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end

            // Dropping the hold or the enable re-arms the long initial delay.
            r_rep <= 1'b0;
            if (w_active) begin
                if (r_rcnt == w_rlast) begin
                    r_rcnt  <= '0;
                    r_first <= 1'b0;
                    r_rep   <= 1'b1;
                end else begin
                    r_rcnt <= r_rcnt + 1'b1;
                end
            end else begin
                r_rcnt  <= '0;
                r_first <= 1'b1;
            end
        end
    end

    assign o_state  = r_state;
    assign o_press  = r_state & ~r_state_d;
    assign o_repeat = r_rep;

endmodule

// File: rtl/button_event_ctrl.sv
// ----------------------------------------------------------------------------
// button_event_ctrl
// Five-button front end: per-channel debounce/repeat, one pending event per
// channel, fixed-priority arbitration into a valid/ready event stream.
//   CLK, RST     : clock, synchronous active-high reset
//   Button[4:0]  : raw buttons (0 up, 1 left, 2 right, 3 down, 4 center)
//   REPEAT_EN    : enables auto-repeat events
//   EVT_READY    : consumer accepts the current event
//   EVT_VALID    : event available
//   EVT_CODE     : button index of the event
//   EVT_REPEAT   : 0 = initial press, 1 = auto-repeat
//   BTN_STATE    : debounced levels
//   OVR_CLR      : clears OVERRUN
//   OVERRUN      : sticky, an event was dropped
// ----------------------------------------------------------------------------
module button_event_ctrl
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1500000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000,
    parameter int CNT_W           = 26
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NUM_BTN-1:0]    Button,
    input  logic                  REPEAT_EN,
    input  logic                  EVT_READY,
    output logic                  EVT_VALID,
    output logic [EVT_CODE_W-1:0] EVT_CODE,
    output logic                  EVT_REPEAT,
    output logic [NUM_BTN-1:0]    BTN_STATE,
    input  logic                  OVR_CLR,
    output logic                  OVERRUN
);

    logic [NUM_BTN-1:0]    w_state;
    logic [NUM_BTN-1:0]    w_press;
    logic [NUM_BTN-1:0]    w_rep;

    genvar g;
    generate
        for (g = int'(BTN_UP); g <= int'(BTN_CENTER); g++) begin : g_ch
            button_debounce_ch #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .REPEAT_DELAY    (REPEAT_DELAY),
                .REPEAT_PERIOD   (REPEAT_PERIOD),
                .CNT_W           (CNT_W)
            ) u_ch (
                .i_clk       (CLK),
                .i_rst       (RST),
                .i_btn       (Button[g]),
                .i_repeat_en (REPEAT_EN),
                .o_state     (w_state[g]),
                .o_press     (w_press[g]),
                .o_repeat    (w_rep[g])
            );
        end
    endgenerate

    logic [NUM_BTN-1:0]    r_pend;
    logic [NUM_BTN-1:0]    r_pend_rep;
    logic                  r_valid;
    logic [EVT_CODE_W-1:0] r_code;
    logic                  r_repeat;
    logic                  r_ovr;

    logic [NUM_BTN-1:0]    w_evt;
    logic [NUM_BTN-1:0]    w_cand;
    logic [NUM_BTN-1:0]    w_onehot;
    logic [NUM_BTN-1:0]    w_take;
    logic [NUM_BTN-1:0]    w_src_rep;
    logic                  w_any;
    logic                  w_load;
    logic                  w_sel_rep;
    logic                  w_drop;

    // Fresh events compete alongside pending ones so a free slot is filled
    // in the very cycle a press pulse appears.
    assign w_evt     = w_press | w_rep;
    assign w_cand    = r_pend | w_evt;
    assign w_any     = |w_cand;
    assign w_onehot  = lowest_onehot(w_cand);
    assign w_load    = ~r_valid | EVT_READY;
    assign w_take    = (w_load && w_any) ? w_onehot : '0;
    // A pending event is older than a fresh one, so it goes out first.
    assign w_src_rep = (r_pend & r_pend_rep) | (~r_pend & w_rep);
    assign w_sel_rep = |(w_onehot & w_src_rep);
    assign w_drop    = |(w_evt & r_pend & ~w_take);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pend     <= '0;
            r_pend_rep <= '0;
            r_valid    <= 1'b0;
            r_code     <= '0;
            r_repeat   <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            if (w_load) begin
                r_valid <= w_any;
                if (w_any) begin
                    r_code   <= onehot_to_idx(w_onehot);
                    r_repeat <= w_sel_rep;
                end
            end

            for (int i = 0; i < NUM_BTN; i++) begin
                if (w_take[i]) begin
                    // Pending entry leaves; a coincident fresh event takes its place.
                    r_pend[i]     <= r_pend[i] & w_evt[i];
                    r_pend_rep[i] <= w_rep[i];
                end else if (w_evt[i] && !r_pend[i]) begin
                    r_pend[i]     <= 1'b1;
                    r_pend_rep[i] <= w_rep[i];
                end
            end

            if (w_drop) begin
                r_ovr <= 1'b1;
            end else if (OVR_CLR) begin
                r_ovr <= 1'b0;
            end
        end
    end

    assign EVT_VALID  = r_valid;
    assign EVT_CODE   = r_code;
    assign EVT_REPEAT = r_repeat;
    assign BTN_STATE  = w_state;
    assign OVERRUN    = r_ovr;

endmodule

// File: tb/tb_button_event_ctrl.sv
// ----------------------------------------------------------------------------
// tb_button_event_ctrl
// Self-checking bench for button_event_ctrl with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=20, REPEAT_PERIOD=8. A timestamp-based model runs on the
// clock and is compared with the DUT every cycle; directed literal checks
// pin latencies, priorities and event counts.
// ----------------------------------------------------------------------------
module tb_button_event_ctrl;

    localparam int DEB = 4;
    localparam int DLY = 20;
    localparam int PER = 8;

    logic       CLK = 1'b0;
    logic       RST;
    logic [4:0] Button;
    logic       REPEAT_EN;
    logic       EVT_READY;
    logic       EVT_VALID;
    logic [2:0] EVT_CODE;
    logic       EVT_REPEAT;
    logic [4:0] BTN_STATE;
    logic       OVR_CLR;
    logic       OVERRUN;

    button_event_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (DLY),
        .REPEAT_PERIOD   (PER),
        .CNT_W           (26)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Button     (Button),
        .REPEAT_EN  (REPEAT_EN),
        .EVT_READY  (EVT_READY),
        .EVT_VALID  (EVT_VALID),
        .EVT_CODE   (EVT_CODE),
        .EVT_REPEAT (EVT_REPEAT),
        .BTN_STATE  (BTN_STATE),
        .OVR_CLR    (OVR_CLR),
        .OVERRUN    (OVERRUN)
    );

    always #5 CLK = ~CLK;

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         edge_n = 0;
    bit         m_init = 0;
    logic [4:0] m_h1, m_h2;          // raw samples 1 and 2 edges old
    logic [4:0] m_state;
    int         m_agree [5];         // last edge where sample agreed with level
    int         m_run   [5];         // first edge of current hold-with-enable, -1 none
    logic [4:0] m_rise, m_rpulse;    // events visible in the current cycle
    int         m_pend  [5];         // -1 empty, 0 press, 1 repeat
    logic       m_v, m_r, m_ovr;
    logic [2:0] m_code;
    int         n_press [5];
    int         n_rept  [5];

    logic [4:0] t_evt, t_rise, t_rp;
    int         t_pick, t_k;
    bit         t_load, t_drop;

    always @(posedge CLK) begin
        edge_n++;
        if (RST) begin
            m_init = 1;
            m_h1 = '0; m_h2 = '0; m_state = '0; m_rise = '0; m_rpulse = '0;
            m_v = 0; m_r = 0; m_ovr = 0; m_code = '0;
            for (int i = 0; i < 5; i++) begin
                m_agree[i] = edge_n; m_run[i] = -1; m_pend[i] = -1;
            end
        end else if (m_init) begin
            t_evt = m_rise | m_rpulse;
            if (m_v && EVT_READY) begin
                if (m_r) n_rept[m_code]++; else n_press[m_code]++;
            end
            t_load = !m_v || EVT_READY;
            t_pick = -1;
            for (int i = 4; i >= 0; i--)
                if (m_pend[i] >= 0 || t_evt[i]) t_pick = i;
            t_drop = 0;
            if (t_load) begin
                m_v = (t_pick >= 0);
                if (t_pick >= 0) begin
                    m_code = 3'(t_pick);
                    m_r = (m_pend[t_pick] >= 0) ? (m_pend[t_pick] == 1) : m_rpulse[t_pick];
                    m_pend[t_pick] = (m_pend[t_pick] >= 0 && t_evt[t_pick])
                                     ? int'(m_rpulse[t_pick]) : -1;
                end
            end
            for (int i = 0; i < 5; i++) begin
                if (t_evt[i] && !(t_load && t_pick == i)) begin
                    if (m_pend[i] >= 0) t_drop = 1;
                    else m_pend[i] = int'(m_rpulse[i]);
                end
            end
            if (t_drop) m_ovr = 1; else if (OVR_CLR) m_ovr = 0;

            // repeat schedule: DLY after hold start, then every PER
            for (int i = 0; i < 5; i++) begin
                t_rp[i] = 1'b0;
                if (m_state[i] && REPEAT_EN) begin
                    if (m_run[i] < 0) m_run[i] = edge_n;
                    t_k = edge_n - m_run[i] + 1 - DLY;
                    t_rp[i] = (t_k >= 0) && (t_k % PER == 0);
                end else begin
                    m_run[i] = -1;
                end
            end
            m_rpulse = t_rp;

            // level flips after DEB consecutive disagreeing samples
            t_rise = '0;
            for (int i = 0; i < 5; i++) begin
                if (m_h2[i] == m_state[i]) m_agree[i] = edge_n;
                else if (edge_n - m_agree[i] == DEB) begin
                    m_state[i] = ~m_state[i];
                    m_agree[i] = edge_n;
                    t_rise[i]  = m_state[i];
                end
            end
            m_rise = t_rise;
            m_h2 = m_h1;
            m_h1 = Button;
        end
    end

    always @(negedge CLK) begin
        if (m_init) begin
            chk("valid",   int'(EVT_VALID),  int'(m_v));
            chk("code",    int'(EVT_CODE),   int'(m_code));
            chk("repeat",  int'(EVT_REPEAT), int'(m_r));
            chk("state",   int'(BTN_STATE),  int'(m_state));
            chk("overrun", int'(OVERRUN),    int'(m_ovr));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic lit_evt(input string nm, input int v, input int code, input int rep);
        chk({nm, "_valid"}, int'(EVT_VALID), v);
        if (v != 0) begin
            chk({nm, "_code"}, int'(EVT_CODE), code);
            chk({nm, "_rep"},  int'(EVT_REPEAT), rep);
        end
    endtask

    int snap_p, snap_r;

    initial begin
        for (int i = 0; i < 5; i++) begin n_press[i] = 0; n_rept[i] = 0; end
        RST = 1; Button = '0; REPEAT_EN = 0; EVT_READY = 1; OVR_CLR = 0;
        cyc(3);
        chk("rst_valid", int'(EVT_VALID), 0);
        chk("rst_state", int'(BTN_STATE), 0);
        chk("rst_ovr",   int'(OVERRUN), 0);
        chk("rst_code",  int'(EVT_CODE), 0);
        RST = 0;
        cyc(2);

        // 1: bounce then press on right
        for (int k = 0; k < 10; k++) begin
            Button[2] = ((k / 2) % 2) == 1;
            cyc(1);
            chk("bounce_novalid", int'(EVT_VALID), 0);
        end
        Button[2] = 1'b1;
        cyc(5);
        chk("t1_state_pre", int'(BTN_STATE), 0);
        cyc(1);
        chk("t1_state", int'(BTN_STATE), 5'b00100);
        chk("t1_novalid", int'(EVT_VALID), 0);
        cyc(1);
        lit_evt("t1_press", 1, 2, 0);
        cyc(1);
        lit_evt("t1_after", 0, 0, 0);

        // 2: auto-repeat on up
        Button = '0;
        cyc(10);
        REPEAT_EN = 1;
        snap_p = n_press[0]; snap_r = n_rept[0];
        Button[0] = 1'b1;
        cyc(7);
        lit_evt("t2_press", 1, 0, 0);
        cyc(19);
        lit_evt("t2_gap", 0, 0, 0);
        cyc(1);
        lit_evt("t2_rep20", 1, 0, 1);
        cyc(8);
        lit_evt("t2_rep28", 1, 0, 1);
        cyc(21);
        Button = '0;
        cyc(20);
        chk("t2_npress", n_press[0] - snap_p, 1);
        chk("t2_nrep",   n_rept[0] - snap_r, 5);

        // 3: simultaneous presses
        REPEAT_EN = 0;
        Button = 5'b10101;
        cyc(7);
        lit_evt("t3_ev0", 1, 0, 0);
        cyc(1);
        lit_evt("t3_ev2", 1, 2, 0);
        cyc(1);
        lit_evt("t3_ev4", 1, 4, 0);
        cyc(1);
        lit_evt("t3_done", 0, 0, 0);
        Button = '0;
        cyc(10);

        // 4: backpressure and overrun on left
        EVT_READY = 0;
        Button[1] = 1'b1;
        cyc(7);
        lit_evt("t4_first", 1, 1, 0);
        Button = '0;      cyc(8);
        Button[1] = 1'b1; cyc(8);
        chk("t4_no_ovr_yet", int'(OVERRUN), 0);
        Button = '0;      cyc(8);
        Button[1] = 1'b1; OVR_CLR = 1;
        cyc(7);
        chk("t4_ovr_setwins", int'(OVERRUN), 1);
        lit_evt("t4_stable", 1, 1, 0);
        cyc(1);
        chk("t4_ovr_clr", int'(OVERRUN), 0);
        OVR_CLR = 0;
        Button = '0;
        cyc(8);
        EVT_READY = 1;
        cyc(1);
        lit_evt("t4_second", 1, 1, 0);
        cyc(1);
        lit_evt("t4_empty", 0, 0, 0);

        // 5: reset mid-hold on down
        EVT_READY = 0;
        Button[3] = 1'b1;
        cyc(7);
        lit_evt("t5_pending", 1, 3, 0);
        RST = 1;
        cyc(1);
        chk("t5_rst_valid", int'(EVT_VALID), 0);
        chk("t5_rst_state", int'(BTN_STATE), 0);
        chk("t5_rst_code",  int'(EVT_CODE), 0);
        RST = 0; EVT_READY = 1;
        cyc(6);
        chk("t5_state", int'(BTN_STATE), 5'b01000);
        cyc(1);
        lit_evt("t5_press", 1, 3, 0);

        // 6: repeat gating on center
        Button = '0;
        cyc(10);
        snap_p = n_press[4]; snap_r = n_rept[4];
        Button[4] = 1'b1;
        cyc(40);
        chk("t6_npress", n_press[4] - snap_p, 1);
        chk("t6_nrep",   n_rept[4] - snap_r, 0);
        REPEAT_EN = 1;
        cyc(20);
        lit_evt("t6_gap", 0, 0, 0);
        cyc(1);
        lit_evt("t6_rep", 1, 4, 1);
        Button = '0; REPEAT_EN = 0;
        cyc(10);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
